dbg_run_ctrl: RTL

//  Debug-module-side run/halt controller: the requesting end of the core debug-mode handshake.

---
 rtl/dbg_run_ctrl_if.sv | 28 ++
 rtl/dbg_run_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dbg_run_ctrl_if.sv
// Run/halt handshake bundle between the debug module, the run controller and the core.
// master drives debugger commands and core status; slave is the controller.
interface dbg_run_ctrl_if;
    logic dm_haltreq;
    logic dm_resumereq;
    logic dm_step;
    logic dm_err_clr;
    logic core_dbg_mode;
    logic core_halt_req;
    logic core_resume_req;
    logic core_step;
    logic dm_halted;
    logic dm_running;
    logic dm_resumeack;
    logic dm_tmo_err;

    modport master (
        output dm_haltreq, dm_resumereq, dm_step, dm_err_clr, core_dbg_mode,
        input  core_halt_req, core_resume_req, core_step,
        input  dm_halted, dm_running, dm_resumeack, dm_tmo_err
    );

    modport slave (
        input  dm_haltreq, dm_resumereq, dm_step, dm_err_clr, core_dbg_mode,
        output core_halt_req, core_resume_req, core_step,
        output dm_halted, dm_running, dm_resumeack, dm_tmo_err
    );
endinterface

// File: rtl/dbg_run_ctrl.sv
// Debug-module side run/halt controller: drives halt/resume/step requests to the core
// and reports halted/running/resumeack plus a sticky handshake-timeout flag.
module dbg_run_ctrl #(
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 200
) (
    input  logic           cpu_clk,
    input  logic           cpu_rstn,
    dbg_run_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        RUNNING     = 3'd0,
        HALT_PEND   = 3'd1,
        HALTED      = 3'd2,
        RESUME_PEND = 3'd3,
        STEP_RUN    = 3'd4
    } state_e;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TMO_CYC);

    state_e           state_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic             core_halt_req_q;
    logic             core_resume_req_q;
    logic             core_step_q;
    logic             dm_halted_q;
    logic             dm_running_q;
    logic             dm_resumeack_q;
    logic             dm_tmo_err_q;
    logic             pend;
    logic             tmo_hit;

    assign pend = (state_q == HALT_PEND) || (state_q == RESUME_PEND);

    // Counter parks one past the trip point so the set event fires once and a
    // later clear is not immediately overridden while the request is still stuck.
    always_comb begin
        tmo_cnt_d = '0;
        if (pend) tmo_cnt_d = (tmo_cnt_q == TMO_SAT) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    end

    assign tmo_hit = pend && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q           <= RUNNING;
            tmo_cnt_q         <= '0;
            core_halt_req_q   <= 1'b0;
            core_resume_req_q <= 1'b0;
            core_step_q       <= 1'b0;
            dm_halted_q       <= 1'b0;
            dm_running_q      <= 1'b1;
            dm_resumeack_q    <= 1'b0;
            dm_tmo_err_q      <= 1'b0;
        end else begin
            core_resume_req_q <= 1'b0;
            tmo_cnt_q         <= tmo_cnt_d;

            if (tmo_hit)            dm_tmo_err_q <= 1'b1;
            else if (bus.dm_err_clr) dm_tmo_err_q <= 1'b0;

            case (state_q)
                RUNNING: begin
                    if (bus.core_dbg_mode) begin
                        state_q      <= HALTED;
                        tmo_cnt_q    <= '0;
                        dm_halted_q  <= 1'b1;
                        dm_running_q <= 1'b0;
                    end else if (bus.dm_haltreq) begin
                        state_q         <= HALT_PEND;
                        tmo_cnt_q       <= '0;
                        core_halt_req_q <= 1'b1;
                    end
                end

                HALT_PEND: begin
                    if (bus.core_dbg_mode) begin
                        state_q         <= HALTED;
                        tmo_cnt_q       <= '0;
                        core_halt_req_q <= 1'b0;
                        dm_halted_q     <= 1'b1;
                        dm_running_q    <= 1'b0;
                    end else if (!bus.dm_haltreq) begin
                        state_q         <= RUNNING;
                        tmo_cnt_q       <= '0;
                        core_halt_req_q <= 1'b0;
                    end
                end

                HALTED: begin
                    // A pending halt request outranks a resume.
                    if (bus.dm_resumereq && !bus.dm_haltreq) begin
                        state_q           <= RESUME_PEND;
                        tmo_cnt_q         <= '0;
                        dm_resumeack_q    <= 1'b0;
                        core_step_q       <= bus.dm_step;
                        core_resume_req_q <= 1'b1;
                    end
                end

                RESUME_PEND: begin
                    if (!bus.core_dbg_mode) begin
                        state_q        <= core_step_q ? STEP_RUN : RUNNING;
                        tmo_cnt_q      <= '0;
                        dm_resumeack_q <= 1'b1;
                        dm_halted_q    <= 1'b0;
                        dm_running_q   <= 1'b1;
                    end
                end

                STEP_RUN: begin
                    // haltreq is deliberately ignored here; the step re-halts on its own.
                    if (bus.core_dbg_mode) begin
                        state_q      <= HALTED;
                        tmo_cnt_q    <= '0;
                        core_step_q  <= 1'b0;
                        dm_halted_q  <= 1'b1;
                        dm_running_q <= 1'b0;
                    end
                end

                default: begin
                    state_q         <= RUNNING;
                    tmo_cnt_q       <= '0;
                    core_halt_req_q <= 1'b0;
                    core_step_q     <= 1'b0;
                    dm_halted_q     <= 1'b0;
                    dm_running_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.core_halt_req   = core_halt_req_q;
    assign bus.core_resume_req = core_resume_req_q;
    assign bus.core_step       = core_step_q;
    assign bus.dm_halted       = dm_halted_q;
    assign bus.dm_running      = dm_running_q;
    assign bus.dm_resumeack    = dm_resumeack_q;
    assign bus.dm_tmo_err      = dm_tmo_err_q;

endmodule
